// File: rtl/disp_pkg.sv
// Shared types and constants for the two-digit seven-segment display controller.
// Build option DISP_BLINK_EN adds the DARK_BLINK state and the blink phase counter.
package disp_pkg;

`ifdef DISP_BLINK_EN
  typedef enum logic [1:0] {
    ST_DARK_INIT  = 2'd0,
    ST_SHOW       = 2'd1,
    ST_DARK_BLINK = 2'd2
  } disp_state_t;
`else
  typedef enum logic [1:0] {
    ST_DARK_INIT = 2'd0,
    ST_SHOW      = 2'd1
  } disp_state_t;
`endif

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int CTRL_BLANK = 0;
  localparam int CTRL_BLINK = 1;
  localparam int CTRL_LZS   = 2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low gfedcba codes; leftmost entry is digit F, rightmost is digit 0.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/disp_seg7_hex.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg7_hex
  import disp_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_HEX[i_nib];

endmodule

// File: rtl/disp_ctrl.sv
// Two-digit hex display controller with DATA/CTRL registers and registered segment outputs.
// Define DISP_BLINK_EN to build the blink phase counter and DARK_BLINK state.
//
// state         | meaning
// ST_DARK_INIT  | blanked; waiting for a DATA write with BLANK=0
// ST_SHOW       | DATA shown as two hex digits (optional leading-zero suppress)
// ST_DARK_BLINK | dark half of the blink cycle (DISP_BLINK_EN only)
module disp_ctrl
  import disp_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int BLINK_DIV = 16
)
(
  input  logic              clock,
  input  logic              n_reset,
  input  logic              wr,
  input  logic              addr,
  input  logic [WORD_W-1:0] data,
  output logic              wr_ack,
  output logic [6:0]        disp0,
  output logic [6:0]        disp1
);

  logic [7:0]  r_data;
  logic [2:0]  r_ctrl;
  logic        r_wr_ack;
  logic [6:0]  r_disp0;
  logic [6:0]  r_disp1;
  disp_state_t r_state;

  logic       w_wr_data;
  logic       w_wr_ctrl;
  logic       w_go_dark;
  logic [7:0] w_data_nxt;
  logic [2:0] w_ctrl_nxt;
  logic [6:0] w_seg_lo;
  logic [6:0] w_seg_hi;
  logic [6:0] w_show1;

`ifdef DISP_BLINK_EN
  localparam int              CNT_W  = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(BLINK_DIV - 1);
  logic [CNT_W-1:0] r_cnt;
`else
  logic w_unused_blink;
  assign w_unused_blink = w_ctrl_nxt[CTRL_BLINK] ^ (BLINK_DIV > 1);
`endif

  generate
    if (WORD_W > 8) begin : g_wide
      logic w_unused_hi;
      assign w_unused_hi = ^data[WORD_W-1:8];
    end
  endgenerate

  assign w_wr_data  = wr && (addr == ADDR_DATA);
  assign w_wr_ctrl  = wr && (addr == ADDR_CTRL);
  assign w_go_dark  = w_wr_ctrl && data[CTRL_BLANK];
  assign w_data_nxt = w_wr_data ? data[7:0] : r_data;
  assign w_ctrl_nxt = w_wr_ctrl ? data[2:0] : r_ctrl;

  // Decode the post-write values so a write shows up in the same edge's output update.
  seg7_hex u_seg_lo (.i_nib(w_data_nxt[3:0]), .o_seg(w_seg_lo));
  seg7_hex u_seg_hi (.i_nib(w_data_nxt[7:4]), .o_seg(w_seg_hi));

  assign w_show1 = (w_ctrl_nxt[CTRL_LZS] && (w_data_nxt[7:4] == 4'h0)) ? SEG_BLANK : w_seg_hi;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_data   <= '0;
      r_ctrl   <= '0;
      r_wr_ack <= 1'b0;
    end else begin
      r_data   <= w_data_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_wr_ack <= wr;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= ST_DARK_INIT;
      r_disp0 <= SEG_BLANK;
      r_disp1 <= SEG_BLANK;
`ifdef DISP_BLINK_EN
      r_cnt   <= '0;
`endif
    end else if (w_go_dark) begin
      r_state <= ST_DARK_INIT;
      r_disp0 <= SEG_BLANK;
      r_disp1 <= SEG_BLANK;
`ifdef DISP_BLINK_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        ST_DARK_INIT: begin
          if (w_wr_data && !r_ctrl[CTRL_BLANK]) begin
            r_state <= ST_SHOW;
            r_disp0 <= w_seg_lo;
            r_disp1 <= w_show1;
`ifdef DISP_BLINK_EN
            r_cnt   <= '0;
`endif
          end else begin
            r_disp0 <= SEG_BLANK;
            r_disp1 <= SEG_BLANK;
          end
        end
        ST_SHOW: begin
`ifdef DISP_BLINK_EN
          if (w_ctrl_nxt[CTRL_BLINK] && (r_cnt == CNT_TC)) begin
            r_state <= ST_DARK_BLINK;
            r_disp0 <= SEG_BLANK;
            r_disp1 <= SEG_BLANK;
            r_cnt   <= '0;
          end else begin
            r_disp0 <= w_seg_lo;
            r_disp1 <= w_show1;
            r_cnt   <= w_ctrl_nxt[CTRL_BLINK] ? r_cnt + CNT_W'(1) : '0;
          end
`else
          r_disp0 <= w_seg_lo;
          r_disp1 <= w_show1;
`endif
        end
`ifdef DISP_BLINK_EN
        ST_DARK_BLINK: begin
          // Dropping BLINK ends the dark phase immediately instead of waiting out the count.
          if (!w_ctrl_nxt[CTRL_BLINK] || (r_cnt == CNT_TC)) begin
            r_state <= ST_SHOW;
            r_disp0 <= w_seg_lo;
            r_disp1 <= w_show1;
            r_cnt   <= '0;
          end else begin
            r_disp0 <= SEG_BLANK;
            r_disp1 <= SEG_BLANK;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
`endif
        default: begin
          r_state <= ST_DARK_INIT;
          r_disp0 <= SEG_BLANK;
          r_disp1 <= SEG_BLANK;
        end
      endcase
    end
  end

  assign wr_ack = r_wr_ack;
  assign disp0  = r_disp0;
  assign disp1  = r_disp1;

endmodule

// File: tb/tb_disp_ctrl.sv
// Self-checking bench for disp_ctrl: behavioural display model checked every cycle plus directed literals.
module tb_disp_ctrl;

  localparam int WORD_W    = 12;
  localparam int BLINK_DIV = 16;
`ifdef DISP_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic              clock   = 1'b0;
  logic              n_reset = 1'b1;
  logic              wr      = 1'b0;
  logic              addr    = 1'b0;
  logic [WORD_W-1:0] data    = '0;
  logic              wr_ack;
  logic [6:0]        disp0;
  logic [6:0]        disp1;

  int n_checks = 0;
  int n_errors = 0;

  disp_ctrl #(.WORD_W(WORD_W), .BLINK_DIV(BLINK_DIV)) dut (
    .clock(clock), .n_reset(n_reset), .wr(wr), .addr(addr), .data(data),
    .wr_ack(wr_ack), .disp0(disp0), .disp1(disp1)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: the display is lit once a DATA write lands while not blanked; with blink on it is
  // dark during every odd BLINK_DIV-long window counted from the moment it was lit.
  logic [7:0] m_data  = '0;
  logic [2:0] m_ctrl  = '0;
  bit         m_lit   = 1'b0;
  int         m_since = 0;
  logic       exp_ack = 1'b0;
  logic [6:0] exp_d0  = 7'h7F;
  logic [6:0] exp_d1  = 7'h7F;

  initial forever begin
    bit entered;
    bit blinking;
    @(posedge clock or negedge n_reset);
    if (!n_reset) begin
      m_data = '0; m_ctrl = '0; m_lit = 1'b0; m_since = 0; exp_ack = 1'b0;
    end else begin
      entered = 1'b0;
      exp_ack = wr;
      if (wr && addr) begin
        m_ctrl = data[2:0];
        if (m_ctrl[0]) m_lit = 1'b0;
      end
      if (wr && !addr) begin
        m_data = data[7:0];
        if (!m_lit && !m_ctrl[0]) begin m_lit = 1'b1; entered = 1'b1; end
      end
      blinking = BLINK_EN && m_ctrl[1];
      if (entered || !m_lit || !blinking) m_since = 0;
      else m_since++;
    end
    blinking = BLINK_EN && m_ctrl[1];
    if (m_lit && (!blinking || ((m_since / BLINK_DIV) % 2 == 0))) begin
      exp_d0 = hexseg(m_data[3:0]);
      exp_d1 = (m_ctrl[2] && m_data[7:4] == 4'h0) ? 7'h7F : hexseg(m_data[7:4]);
    end else begin
      exp_d0 = 7'h7F;
      exp_d1 = 7'h7F;
    end
  end

  initial forever begin
    @(negedge clock);
    check("model_wr_ack", {6'b0, wr_ack}, {6'b0, exp_ack});
    check("model_disp0", disp0, exp_d0);
    check("model_disp1", disp1, exp_d1);
  end

  task automatic do_write(input logic a, input logic [WORD_W-1:0] d);
    @(negedge clock);
    wr = 1'b1; addr = a; data = d;
    @(negedge clock);
    wr = 1'b0;
  endtask

  task automatic lit(input string name, input logic [6:0] e1, input logic [6:0] e0);
    check({name, "_d1"}, disp1, e1);
    check({name, "_d0"}, disp0, e0);
  endtask

  initial begin
    #1 n_reset = 1'b0;
    repeat (3) @(negedge clock);
    lit("in_reset", 7'h7F, 7'h7F);
    n_reset = 1'b1;
    repeat (6) @(negedge clock);
    lit("idle", 7'h7F, 7'h7F);
    check("idle_ack", {6'b0, wr_ack}, 7'h00);

    do_write(1'b0, 12'hFA5);
    check("a5_ack", {6'b0, wr_ack}, 7'h01);
    lit("a5", 7'h08, 7'h12);
    @(negedge clock);
    check("a5_ack_drop", {6'b0, wr_ack}, 7'h00);

    do_write(1'b1, 12'h004);
    do_write(1'b0, 12'hF07); lit("lzs_07", 7'h7F, 7'h78);
    do_write(1'b0, 12'h010); lit("lzs_10", 7'h79, 7'h40);
    do_write(1'b0, 12'h000); lit("lzs_00", 7'h7F, 7'h40);

    do_write(1'b1, 12'h000);
    do_write(1'b0, 12'h03C); lit("show_3c", 7'h30, 7'h46);
    do_write(1'b1, 12'h001); lit("blank", 7'h7F, 7'h7F);
    do_write(1'b0, 12'h055); lit("data_while_blank", 7'h7F, 7'h7F);
    do_write(1'b1, 12'h000); lit("unblank_no_data", 7'h7F, 7'h7F);
    do_write(1'b0, 12'h03C); lit("reshow_3c", 7'h30, 7'h46);

    @(negedge clock);
    wr = 1'b1; addr = 1'b0; data = 12'h012;
    @(negedge clock);
    check("b2b_ack1", {6'b0, wr_ack}, 7'h01);
    data = 12'h034;
    @(negedge clock);
    wr = 1'b0;
    check("b2b_ack2", {6'b0, wr_ack}, 7'h01);
    lit("b2b_34", 7'h30, 7'h19);
    @(negedge clock);
    check("b2b_ack_end", {6'b0, wr_ack}, 7'h00);

    do_write(1'b1, 12'h003);
    do_write(1'b1, 12'h002);
    do_write(1'b0, 12'h0FF); lit("blink_e0", 7'h0E, 7'h0E);
    repeat (15) @(negedge clock);
`ifdef DISP_BLINK_EN
    lit("blink_e15", 7'h0E, 7'h0E);
    @(negedge clock); lit("blink_e16", 7'h7F, 7'h7F);
    repeat (4) @(negedge clock); lit("blink_e20", 7'h7F, 7'h7F);
    do_write(1'b1, 12'h000); lit("blink_clear", 7'h0E, 7'h0E);
    do_write(1'b1, 12'h002);
    repeat (20) @(negedge clock);
`else
    lit("noblink_e15", 7'h0E, 7'h0E);
    @(negedge clock); lit("noblink_e16", 7'h0E, 7'h0E);
    repeat (10) @(negedge clock); lit("noblink_e26", 7'h0E, 7'h0E);
`endif

    @(negedge clock);
    wr = 1'b1; addr = 1'b0; data = 12'h0AB;
    #2 n_reset = 1'b0;
    #1 lit("rst_async", 7'h7F, 7'h7F);
    check("rst_async_ack", {6'b0, wr_ack}, 7'h00);
    @(negedge clock);
    wr = 1'b0;
    @(negedge clock);
    n_reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_no_ack", {6'b0, wr_ack}, 7'h00);
    lit("rst_release", 7'h7F, 7'h7F);
    do_write(1'b1, 12'h000); lit("rst_ctrl0", 7'h7F, 7'h7F);
    do_write(1'b0, 12'h000); lit("rst_data00", 7'h40, 7'h40);
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
